// File: rtl/jtframe_rom_arb.sv
// Four-slot ROM read arbiter: a one-entry cache per slot in front of a single SDRAM port.
// Slot 0 has fixed highest priority; misses are fetched one at a time.
module jtframe_rom_arb #(
  parameter logic [21:0] SLOT0_OFFSET = 22'h0,
  parameter logic [21:0] SLOT1_OFFSET = 22'h0,
  parameter logic [21:0] SLOT2_OFFSET = 22'h0,
  parameter logic [21:0] SLOT3_OFFSET = 22'h0
) (
  input  logic          clk_rom,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic          loop_rst,
  input  logic [3:0]    slot_cs,
  input  logic [87:0]   slot_addr,
  output logic [3:0]    slot_ok,
  output logic [127:0]  slot_dout,
  output logic          sdram_req,
  input  logic          sdram_ack,
  output logic [21:0]   sdram_addr,
  input  logic [31:0]   data_read,
  input  logic          data_rdy,
  output logic          refresh_en
);

  typedef enum logic [1:0] {StIdle, StWaitAck, StWaitData} state_e;

  localparam logic [3:0][21:0] Offsets = {SLOT3_OFFSET, SLOT2_OFFSET, SLOT1_OFFSET, SLOT0_OFFSET};

  state_e            state_q, state_d;
  logic [3:0]        valid_q, valid_d;
  logic [3:0][21:0]  tag_q, tag_d;
  logic [3:0][31:0]  data_q, data_d;
  logic [1:0]        slot_q, slot_d;
  logic [21:0]       ltag_q, ltag_d;
  logic              req_q, req_d;
  logic [21:0]       addr_q, addr_d;

  logic [3:0][21:0]  addr_w;
  logic [3:0]        need;
  logic [1:0]        sel;
  logic              halt;

  assign addr_w     = slot_addr;
  assign halt       = downloading | loop_rst;
  assign slot_dout  = data_q;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  always_comb begin
    slot_ok = '0;
    for (int i = 0; i < 4; i++) begin
      slot_ok[i] = slot_cs[i] & valid_q[i] & (tag_q[i] == addr_w[i]) & ~halt;
    end
  end

  assign need = slot_cs & ~slot_ok;

  // Scan downwards so the lowest pending index wins.
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (need[i]) sel = 2'(i);
    end
  end

  // rst_n gates the output so refresh stays off while the block is held in reset.
  assign refresh_en = rst_n & ~halt & (state_q == StIdle) & ~(|need);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    slot_d  = slot_q;
    ltag_d  = ltag_q;
    req_d   = req_q;
    addr_d  = addr_q;
    if (halt) begin
      state_d = StIdle;
      req_d   = 1'b0;
      valid_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|need) begin
            slot_d  = sel;
            ltag_d  = addr_w[sel];
            addr_d  = addr_w[sel] + Offsets[sel];
            req_d   = 1'b1;
            state_d = StWaitAck;
          end
        end
        StWaitAck: begin
          if (sdram_ack) begin
            req_d   = 1'b0;
            state_d = StWaitData;
          end
        end
        StWaitData: begin
          // Fill under the latched tag even if the requester moved on meanwhile.
          if (data_rdy) begin
            data_d[slot_q]  = data_read;
            tag_d[slot_q]   = ltag_q;
            valid_d[slot_q] = 1'b1;
            state_d         = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      slot_q  <= '0;
      ltag_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      slot_q  <= slot_d;
      ltag_q  <= ltag_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed bench for jtframe_rom_arb: expected SDRAM addresses and fill slots are queued
// when a request is posed and checked when the arbiter issues it.
module tb_jtframe_rom_arb;

  localparam logic [21:0] Off0 = 22'h3FFFFF;
  localparam logic [21:0] Off1 = 22'h10000;
  localparam logic [21:0] Off2 = 22'h0;
  localparam logic [21:0] Off3 = 22'h0;

  logic          clk_rom = 1'b0;
  logic          rst_n, downloading, loop_rst, sdram_ack, data_rdy;
  logic [3:0]    slot_cs, slot_ok;
  logic [87:0]   slot_addr;
  logic [127:0]  slot_dout;
  logic          sdram_req, refresh_en;
  logic [21:0]   sdram_addr;
  logic [31:0]   data_read;

  int checks = 0;
  int failures = 0;

  logic [21:0] exp_addr_q[$];
  int          exp_slot_q[$];
  logic [31:0] model_dout[4];

  jtframe_rom_arb #(
    .SLOT0_OFFSET(Off0),
    .SLOT1_OFFSET(Off1),
    .SLOT2_OFFSET(Off2),
    .SLOT3_OFFSET(Off3)
  ) dut (
    .clk_rom    (clk_rom),
    .rst_n      (rst_n),
    .downloading(downloading),
    .loop_rst   (loop_rst),
    .slot_cs    (slot_cs),
    .slot_addr  (slot_addr),
    .slot_ok    (slot_ok),
    .slot_dout  (slot_dout),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .sdram_addr (sdram_addr),
    .data_read  (data_read),
    .data_rdy   (data_rdy),
    .refresh_en (refresh_en)
  );

  always #5 clk_rom = ~clk_rom;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_pack();
    return {model_dout[3], model_dout[2], model_dout[1], model_dout[0]};
  endfunction

  function automatic logic [21:0] map_addr(input int s, input logic [21:0] a);
    case (s)
      0:       return a + Off0;
      1:       return a + Off1;
      2:       return a + Off2;
      default: return a + Off3;
    endcase
  endfunction

  task automatic step();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_rom);
  endtask

  task automatic set_addr(input int s, input logic [21:0] a);
    slot_addr[22*s +: 22] = a;
  endtask

  task automatic expect_req(input int s, input logic [21:0] a);
    exp_addr_q.push_back(map_addr(s, a));
    exp_slot_q.push_back(s);
  endtask

  task automatic issue_check(output int s);
    bit seen = 0;
    logic [21:0] e;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (sdram_req === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("req_timeout", sdram_req, 1'b1);
    e = exp_addr_q.pop_front();
    s = exp_slot_q.pop_front();
    chk("sdram_addr", sdram_addr, e);
  endtask

  task automatic ack_it();
    step();
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    smp();
    chk("req_drop_after_ack", sdram_req, 1'b0);
  endtask

  task automatic deliver(input int s, input logic [31:0] d);
    step();
    data_rdy  = 1'b1;
    data_read = d;
    step();
    data_rdy  = 1'b0;
    model_dout[s] = d;
    smp();
    chk("slot_dout_fill", slot_dout, model_pack());
  endtask

  task automatic serve(input logic [31:0] d);
    int s;
    issue_check(s);
    ack_it();
    deliver(s, d);
  endtask

  initial begin
    int s;
    int reqs;
    for (int i = 0; i < 4; i++) model_dout[i] = '0;
    rst_n = 1'b0; downloading = 1'b0; loop_rst = 1'b0; sdram_ack = 1'b0;
    data_rdy = 1'b0; data_read = '0; slot_cs = 4'hF; slot_addr = '0;
    #2;
    chk("rst_slot_ok", slot_ok, 4'h0);
    chk("rst_slot_dout", slot_dout, 128'h0);
    chk("rst_sdram_req", sdram_req, 1'b0);
    chk("rst_sdram_addr", sdram_addr, 22'h0);
    chk("rst_refresh_en", refresh_en, 1'b0);
    step(); step();
    rst_n = 1'b1;
    slot_cs = 4'h0;
    smp();
    chk("idle_refresh_en", refresh_en, 1'b1);

    // Slot 1 miss with offset
    step();
    set_addr(1, 22'h00100);
    slot_cs = 4'b0010;
    expect_req(1, 22'h00100);
    smp();
    chk("miss_refresh_off", refresh_en, 1'b0);
    chk("miss_slot_ok", slot_ok, 4'b0000);
    serve(32'hDEADBEEF);
    chk("s1_ok_after_fill", slot_ok, 4'b0010);

    // Hit: no new request
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      smp();
      if (sdram_req === 1'b1) reqs++;
    end
    chk("hit_no_req", reqs, 0);
    chk("hit_refresh_en", refresh_en, 1'b1);

    // data_rdy in IDLE is ignored
    step();
    data_rdy = 1'b1;
    data_read = 32'h12345678;
    step();
    data_rdy = 1'b0;
    smp();
    chk("idle_data_rdy_ignored", slot_dout, model_pack());

    // Slots 0 and 3 together; slot 0 address wraps through its offset
    step();
    set_addr(0, 22'h2);
    set_addr(3, 22'h33);
    slot_cs = 4'b1001;
    expect_req(0, 22'h2);
    expect_req(3, 22'h33);
    chk("wrap_model", exp_addr_q[0], 22'h000001);
    serve(32'hA0A0A0A0);
    chk("s0_first_ok", slot_ok, 4'b0001);
    serve(32'h33330000);
    chk("s0_s3_ok", slot_ok, 4'b1001);

    // Slot 2 address moves while data is in flight
    step();
    set_addr(2, 22'h5);
    slot_cs = 4'b0100;
    expect_req(2, 22'h5);
    issue_check(s);
    ack_it();
    step();
    set_addr(2, 22'h6);
    expect_req(2, 22'h6);
    data_rdy = 1'b1;
    data_read = 32'h55555555;
    step();
    data_rdy = 1'b0;
    model_dout[2] = 32'h55555555;
    smp();
    chk("stale_fill_not_ok", slot_ok, 4'b0000);
    chk("stale_fill_dout", slot_dout, model_pack());
    serve(32'h66666666);
    chk("s2_refetch_ok", slot_ok, 4'b0100);

    // loop_rst during WAIT_ACK
    step();
    set_addr(1, 22'h200);
    slot_cs = 4'b0010;
    expect_req(1, 22'h200);
    issue_check(s);
    step();
    loop_rst = 1'b1;
    slot_cs = 4'b1111;
    smp();
    chk("loop_rst_slot_ok", slot_ok, 4'b0000);
    chk("loop_rst_refresh", refresh_en, 1'b0);
    step();
    loop_rst = 1'b0;
    slot_cs = 4'b0000;
    smp();
    chk("loop_rst_req_cleared", sdram_req, 1'b0);
    step();
    data_rdy = 1'b1;
    data_read = 32'hBAD0BAD0;
    step();
    data_rdy = 1'b0;
    smp();
    chk("loop_rst_late_data_ignored", slot_dout, model_pack());
    chk("loop_rst_idle_refresh", refresh_en, 1'b1);
    step();
    slot_cs = 4'b0001;
    expect_req(0, 22'h2);
    smp();
    chk("valid_cleared_by_loop_rst", slot_ok, 4'b0000);
    serve(32'h0F0F0F0F);
    chk("s0_refill_ok", slot_ok, 4'b0001);

    // downloading blocks service
    step();
    downloading = 1'b1;
    smp();
    chk("dl_slot_ok", slot_ok, 4'b0000);
    chk("dl_refresh", refresh_en, 1'b0);
    step();
    smp();
    chk("dl_no_req", sdram_req, 1'b0);
    step();
    downloading = 1'b0;
    slot_cs = 4'b0000;

    // Reset mid-transaction discards it
    step();
    set_addr(3, 22'h44);
    slot_cs = 4'b1000;
    expect_req(3, 22'h44);
    issue_check(s);
    ack_it();
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) model_dout[i] = '0;
    #1;
    chk("midrst_req", sdram_req, 1'b0);
    chk("midrst_addr", sdram_addr, 22'h0);
    chk("midrst_dout", slot_dout, model_pack());
    step();
    rst_n = 1'b1;
    slot_cs = 4'b0000;
    step();
    data_rdy = 1'b1;
    data_read = 32'h77777777;
    step();
    data_rdy = 1'b0;
    smp();
    chk("midrst_no_fill", slot_dout, model_pack());
    chk("midrst_req_idle", sdram_req, 1'b0);

    chk("scoreboard_empty", exp_addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
